pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 id_rs1, id_rs2  input  5 each  source registers of the instruction in decode.
REQ-004 id_use_rs1, id_use_rs2  input  1 each  decode instruction actually reads rs1/rs2.
REQ-005 ex_rd  input  5  destination register of the instruction in EX.
REQ-006 ex_load  input  1  EX instruction is a load (io_ops load class).
REQ-007 mem_req  input  1  memory access outstanding in MA this cycle.
REQ-008 mem_ready  input  1  memory access completes this cycle.
REQ-009 bj_en  input  1  taken branch/jump redirect from EX.
REQ-010 trap_en  input  1  trap redirect from the system unit.
REQ-011 stall  output  1  hold fetch, decode and the ID/EX register.
REQ-012 clear  output  1  load a bubble into the ID/EX register.
REQ-013 flush  output  1  kill fetch/decode contents (redirect in progress).
REQ-014 state  output  2  FSM state for debug: 0 RUN, 1 MEMWAIT, 2 FLUSH1, 3 FLUSH2.
REQ-015 stall_cnt  output  32  performance count of cycles with stall=1.

Function
REQ-016 Outputs stall/clear/flush SHALL be combinational in state, pend_bj and current inputs; state, pend_bj and stall_cnt SHALL be registered.
REQ-017 Hazard term hz SHALL be ex_load & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)); x0 never hazards.
REQ-018 Event priority in every state SHALL be trap_en > memory wait > bj_en > hz.
REQ-019 RUN, trap_en=1: flush=1, clear=1, stall=0; next FLUSH1; pend_bj cleared.
REQ-020 RUN, mem_req & !mem_ready: stall=1, clear=0, flush=0; next MEMWAIT; if bj_en=1 same cycle, pend_bj set.
REQ-021 RUN, bj_en=1 (no trap, no wait): flush=1, clear=1; next FLUSH1.
REQ-022 RUN, hz=1 only: stall=1, clear=1 for exactly that cycle (one-bubble load-use); stay RUN.
REQ-023 RUN, no event: all three outputs 0.
REQ-024 MEMWAIT: stall=1 while mem_ready=0; bj_en asserted here SHALL set pend_bj (held, not lost).
REQ-025 MEMWAIT, mem_ready=1: stall=0; if pend_bj|bj_en then flush=1, clear=1, next FLUSH1, pend_bj cleared; else next RUN.
REQ-026 MEMWAIT, trap_en=1: overrides wait; flush=1, clear=1, stall=0, next FLUSH1, pend_bj cleared.
REQ-027 FLUSH1: clear=1, flush=1, stall=0; next FLUSH2; FLUSH2: clear=1, flush=0; next RUN (total 3-cycle redirect penalty).
REQ-028 trap_en in FLUSH1/FLUSH2 SHALL restart at FLUSH1 with flush=1, clear=1; bj_en and hz SHALL be ignored in FLUSH states.
REQ-029 stall_cnt SHALL increment by 1 each cycle stall=1 and saturate at 32'hFFFF_FFFF (no wrap).

Reset
REQ-030 rst_n=0 at a rising edge SHALL set state=RUN, pend_bj=0, stall_cnt=0, regardless of any other input or current state (including mid-MEMWAIT or mid-FLUSH).
REQ-031 While rst_n=0, stall=0, clear=1, flush=1 (pipeline held empty); first cycle after release behaves as RUN.

Verification
REQ-032 ex_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 in RUN -> one cycle stall=1, clear=1, state stays 0, stall_cnt=1; same with ex_rd=0 -> no stall.
REQ-033 mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1 -> stall=1 for 4 cycles, state=1, then 0; stall_cnt=4.
REQ-034 bj_en pulsed during 2nd MEMWAIT cycle, mem_ready on 4th -> on 4th cycle flush=1, clear=1; then state 2, 3, 0.
REQ-035 trap_en=1 simultaneously with bj_en and hz in RUN -> flush=1, clear=1, stall=0, next states 2, 3, 0; trap_en again in state 3 -> back to 2.
REQ-036 rst_n=0 for one edge while state=1 with stall_cnt=7 -> state=0, stall_cnt=0, pend_bj=0; preloaded stall_cnt=32'hFFFF_FFFF with stall=1 -> stays FFFF_FFFF.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard/redirect controller.
// The master drives hazard/event inputs; the slave (pipe_ctrl) returns control and debug outputs.
interface pipe_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  ex_rd;
    logic        ex_load;
    logic        mem_req;
    logic        mem_ready;
    logic        bj_en;
    logic        trap_en;
    logic        stall;
    logic        clear;
    logic        flush;
    logic [1:0]  state;
    logic [31:0] stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_load,
               mem_req, mem_ready, bj_en, trap_en,
        input  stall, clear, flush, state, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_load,
               mem_req, mem_ready, bj_en, trap_en,
        output stall, clear, flush, state, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: load-use bubbles, memory-wait stalls,
// branch/trap flushes with a 3-cycle redirect penalty, and a saturating stall counter.
module pipe_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        FLUSH1  = 2'd2,
        FLUSH2  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        pend_bj_q, pend_bj_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall_c, clear_c, flush_c;
    logic        hz;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign hz = bus.ex_load && (bus.ex_rd != 5'd0) &&
                ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                 (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

    always_comb begin
        state_d   = state_q;
        pend_bj_d = pend_bj_q;
        stall_c   = 1'b0;
        clear_c   = 1'b0;
        flush_c   = 1'b0;
        if (!rst_n) begin
            clear_c = 1'b1;
            flush_c = 1'b1;
        end else if (bus.trap_en) begin
            clear_c   = 1'b1;
            flush_c   = 1'b1;
            state_d   = FLUSH1;
            pend_bj_d = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.mem_req && !bus.mem_ready) begin
                        stall_c   = 1'b1;
                        state_d   = MEMWAIT;
                        pend_bj_d = bus.bj_en;
                    end else if (bus.bj_en) begin
                        clear_c = 1'b1;
                        flush_c = 1'b1;
                        state_d = FLUSH1;
                    end else if (hz) begin
                        stall_c = 1'b1;
                        clear_c = 1'b1;
                    end
                end
                MEMWAIT: begin
                    // A redirect seen while the memory is busy is remembered until the access ends.
                    if (!bus.mem_ready) begin
                        stall_c   = 1'b1;
                        pend_bj_d = pend_bj_q | bus.bj_en;
                    end else if (pend_bj_q || bus.bj_en) begin
                        clear_c   = 1'b1;
                        flush_c   = 1'b1;
                        state_d   = FLUSH1;
                        pend_bj_d = 1'b0;
                    end else begin
                        state_d = RUN;
                    end
                end
                FLUSH1: begin
                    clear_c = 1'b1;
                    flush_c = 1'b1;
                    state_d = FLUSH2;
                end
                FLUSH2: begin
                    clear_c = 1'b1;
                    state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign stall_cnt_d = (stall_c && (stall_cnt_q != 32'hFFFF_FFFF)) ?
                         stall_cnt_q + 32'd1 : stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pend_bj_q   <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pend_bj_q   <= pend_bj_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall     = stall_c;
    assign bus.clear     = clear_c;
    assign bus.flush     = flush_c;
    assign bus.state     = state_q;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: each driven cycle pushes its expected
// {state, stall, clear, flush, stall_cnt}; a monitor pops and compares it mid-cycle.
module tb_pipe_ctrl;
    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] ex_rd;
        logic       ex_load;
        logic       mem_req;
        logic       mem_ready;
        logic       bj;
        logic       trap;
    } stim_t;

    localparam int W = 37;

    logic clk;
    logic rst_n;
    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    logic [31:0]  exp_cnt;
    int           n_checks;
    int           n_fail;
    stim_t        s;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t t;
        t = '0;
        t.rst_n = 1'b1;
        return t;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (state,stall,clear,flush,cnt)", tag, got, exp);
        end
    endtask

    task automatic apply(input stim_t t);
        rst_n             = t.rst_n;
        bus.id_rs1        = t.rs1;
        bus.id_rs2        = t.rs2;
        bus.id_use_rs1    = t.use1;
        bus.id_use_rs2    = t.use2;
        bus.ex_rd         = t.ex_rd;
        bus.ex_load       = t.ex_load;
        bus.mem_req       = t.mem_req;
        bus.mem_ready     = t.mem_ready;
        bus.bj_en         = t.bj;
        bus.trap_en       = t.trap;
    endtask

    // One cycle of stimulus; scf = {stall, clear, flush} expected during this cycle.
    task automatic step(input string tag, input stim_t t, input logic [1:0] st, input logic [2:0] scf);
        @(negedge clk);
        apply(t);
        exp_q.push_back({st, scf, exp_cnt});
        tag_q.push_back(tag);
        if (!t.rst_n)
            exp_cnt = 32'd0;
        else if (scf[2] && exp_cnt != 32'hFFFF_FFFF)
            exp_cnt = exp_cnt + 32'd1;
    endtask

    initial begin : monitor
        logic [W-1:0] e;
        string        t;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check_eq(t, {27'd0, bus.state, bus.stall, bus.clear, bus.flush, bus.stall_cnt},
                         {27'd0, e});
            end
        end
    end

    initial begin : driver
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 32'd0;
        s = idle();
        s.rst_n = 1'b0;
        apply(s);
        @(negedge clk);
        // Reset held with events asserted: pipeline stays empty, state already RUN.
        s.trap = 1'b1; s.bj = 1'b1; s.mem_req = 1'b1;
        step("rst_hold", s, 2'd0, 3'b011);
        s = idle();
        step("run_idle", s, 2'd0, 3'b000);

        // Load-use hazards.
        s.ex_load = 1'b1; s.ex_rd = 5'd5; s.rs2 = 5'd5; s.use2 = 1'b1;
        step("lu_rs2", s, 2'd0, 3'b110);
        s = idle();
        step("lu_after", s, 2'd0, 3'b000);
        s.ex_load = 1'b1; s.ex_rd = 5'd0; s.rs2 = 5'd0; s.use2 = 1'b1;
        step("lu_x0", s, 2'd0, 3'b000);
        s.ex_rd = 5'd7; s.rs1 = 5'd7; s.use1 = 1'b0; s.rs2 = 5'd3;
        step("lu_nouse", s, 2'd0, 3'b000);
        s.use1 = 1'b1;
        step("lu_rs1", s, 2'd0, 3'b110);
        s.ex_load = 1'b0;
        step("no_load", s, 2'd0, 3'b000);

        // Four-cycle memory wait.
        s = idle(); s.mem_req = 1'b1;
        step("mw0", s, 2'd0, 3'b100);
        for (int i = 1; i < 4; i++) step($sformatf("mw%0d", i), s, 2'd1, 3'b100);
        s.mem_ready = 1'b1;
        step("mw_done", s, 2'd1, 3'b000);
        step("mw_hit", s, 2'd0, 3'b000);
        s = idle();
        step("mw_run", s, 2'd0, 3'b000);

        // Branch during the wait is held until the access completes.
        s.mem_req = 1'b1;
        step("pb0", s, 2'd0, 3'b100);
        s.bj = 1'b1;
        step("pb1", s, 2'd1, 3'b100);
        s.bj = 1'b0;
        step("pb2", s, 2'd1, 3'b100);
        s.mem_ready = 1'b1;
        step("pb3", s, 2'd1, 3'b011);
        s = idle();
        step("pb_f1", s, 2'd2, 3'b011);
        step("pb_f2", s, 2'd3, 3'b010);
        step("pb_run", s, 2'd0, 3'b000);

        // Branch in the same cycle a wait starts.
        s.mem_req = 1'b1; s.bj = 1'b1;
        step("wb0", s, 2'd0, 3'b100);
        s.bj = 1'b0; s.mem_ready = 1'b1;
        step("wb1", s, 2'd1, 3'b011);
        s = idle();
        step("wb_f1", s, 2'd2, 3'b011);
        step("wb_f2", s, 2'd3, 3'b010);
        step("wb_run", s, 2'd0, 3'b000);

        // Plain branch beats a hazard; branch and hazard ignored in flush states.
        s.bj = 1'b1; s.ex_load = 1'b1; s.ex_rd = 5'd4; s.rs1 = 5'd4; s.use1 = 1'b1;
        step("bj", s, 2'd0, 3'b011);
        step("bj_f1", s, 2'd2, 3'b011);
        step("bj_f2", s, 2'd3, 3'b010);
        s = idle();
        step("bj_run", s, 2'd0, 3'b000);

        // Trap beats wait, branch and hazard; trap in FLUSH2 restarts.
        s.trap = 1'b1; s.bj = 1'b1; s.mem_req = 1'b1;
        s.ex_load = 1'b1; s.ex_rd = 5'd9; s.rs1 = 5'd9; s.use1 = 1'b1;
        step("tr0", s, 2'd0, 3'b011);
        s.trap = 1'b0; s.mem_req = 1'b0;
        step("tr_f1", s, 2'd2, 3'b011);
        s.trap = 1'b1;
        step("tr_f2_trap", s, 2'd3, 3'b011);
        s = idle();
        step("tr_f1b", s, 2'd2, 3'b011);
        step("tr_f2b", s, 2'd3, 3'b010);
        step("tr_run", s, 2'd0, 3'b000);

        // Trap overrides a memory wait.
        s.mem_req = 1'b1;
        step("mt0", s, 2'd0, 3'b100);
        s.trap = 1'b1;
        step("mt_trap", s, 2'd1, 3'b011);
        s = idle();
        step("mt_f1", s, 2'd2, 3'b011);
        step("mt_f2", s, 2'd3, 3'b010);
        step("mt_run", s, 2'd0, 3'b000);

        // Reset mid-MEMWAIT with a pending branch: pending branch must be dropped.
        s.mem_req = 1'b1; s.bj = 1'b1;
        step("rp0", s, 2'd0, 3'b100);
        s.bj = 1'b0;
        step("rp1", s, 2'd1, 3'b100);
        s.rst_n = 1'b0;
        step("rp_rst", s, 2'd1, 3'b011);
        s = idle(); s.mem_req = 1'b1;
        step("rp2", s, 2'd0, 3'b100);
        s.mem_ready = 1'b1;
        step("rp3", s, 2'd1, 3'b000);
        s = idle();
        step("rp_run", s, 2'd0, 3'b000);

        // Reset mid-flush.
        s.bj = 1'b1;
        step("rf_bj", s, 2'd0, 3'b011);
        s = idle(); s.rst_n = 1'b0;
        step("rf_rst", s, 2'd2, 3'b011);
        s = idle();
        step("rf_run", s, 2'd0, 3'b000);

        // Saturation: deposit a near-max count between the monitor sample and the next edge.
        #3;
        dut.stall_cnt_q = 32'hFFFF_FFFE;
        exp_cnt = 32'hFFFF_FFFE;
        s.mem_req = 1'b1;
        step("sat0", s, 2'd0, 3'b100);
        step("sat1", s, 2'd1, 3'b100);
        step("sat2", s, 2'd1, 3'b100);
        s.mem_ready = 1'b1;
        step("sat3", s, 2'd1, 3'b000);
        s = idle();
        step("sat_run", s, 2'd0, 3'b000);

        #5;
        if (exp_q.size() != 0) check_eq("queue_drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
